// File: rtl/rf_write_arbiter_pkg.sv
// Shared types and constants for the register-file write arbiter and its LU result FIFO.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   REG_ADDR_W / DATA_W / ENTRY_W : write-port field widths
//   REG_ZERO                      : hard-wired zero register, never actually written
//   arb_state_e                   : RUN -> DRAIN -> HALTED sequencing
//   gnt_src_e                     : which requester owns the write port this cycle
//   rf_wr_t                       : one queued or granted write {addr, data}
//   writes_rf()                   : true when a grant really updates the register file
package rf_write_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int ENTRY_W    = REG_ADDR_W + DATA_W;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WB   = 2'd1,
    GNT_LU   = 2'd2,
    GNT_DBG  = 2'd3
  } gnt_src_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } rf_wr_t;

  // A grant to r0 still consumes the request but must not touch the file.
  function automatic logic writes_rf(input gnt_src_e src, input logic [REG_ADDR_W-1:0] addr);
    return (src != GNT_NONE) && (addr != REG_ZERO);
  endfunction

endpackage

// File: rtl/rf_wr_fifo.sv
// Small synchronous FIFO holding long-latency-unit results until the write port is free.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: pushes while full are dropped (caller must gate with !full); pops while empty are ignored.
//
// Ports:
//   clk, reset     : clock, synchronous active-high reset (empties the FIFO)
//   push_vld/_dat  : write one entry at the tail
//   pop            : consume the head entry
//   head_dat       : current head entry (valid when !empty)
//   full, empty    : occupancy flags, from the registered count
//   count          : number of stored entries, 0..DEPTH
module rf_wr_fifo
  import rf_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = ENTRY_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_vld,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_dat,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    // Full/empty come from the pre-pop count, so a pop cannot make room
    // for a push in the same cycle.
    do_push  = push_vld && (count_q != DEPTH_C);
    do_pop   = pop && (count_q != '0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + 1'b1;   // DEPTH is a power of 2: wraps naturally
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is read while count is zero.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign count    = count_q;

endmodule

// File: rtl/rf_write_arbiter.sv
// Owns the single register-file write port, shared by WB, the long-latency unit (via FIFO) and debug.
// Latency: WB/debug writes land combinationally in the same cycle; LU results are written no earlier than the next cycle.
// Backpressure: LU_Ready drops when the FIFO is full or the core is halted; Stall_Req asks for bubbles when the FIFO head starves.
//
// Ports:
//   clk, reset                              : clock, synchronous active-high reset
//   WB_C_RegWrite, WB_RegToWrite, WB_Result : in-order WB write request (highest priority)
//   WB_C_Halt                               : halt retiring in WB, starts the drain
//   LU_Valid, LU_Reg, LU_Data, LU_Ready     : LU result handshake into the FIFO
//   LU_Busy                                 : LU has work in flight (holds off HALTED)
//   DBG_Write, DBG_Reg, DBG_Data            : debug write, only honoured once halted
//   RF_WE, RF_WAddr, RF_WData               : register-file write port
//   Stall_Req                               : registered bubble request for the hazard unit
//   Halted                                  : registered, drain finished and port frozen to debug
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        WB_C_RegWrite,
  input  logic [4:0]  WB_RegToWrite,
  input  logic [31:0] WB_Result,
  input  logic        WB_C_Halt,
  input  logic        LU_Valid,
  input  logic [4:0]  LU_Reg,
  input  logic [31:0] LU_Data,
  input  logic        LU_Busy,
  output logic        LU_Ready,
  input  logic        DBG_Write,
  input  logic [4:0]  DBG_Reg,
  input  logic [31:0] DBG_Data,
  output logic        RF_WE,
  output logic [4:0]  RF_WAddr,
  output logic [31:0] RF_WData,
  output logic        Stall_Req,
  output logic        Halted
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] STARVE_LIMIT_C = SC_W'(STARVE_LIMIT);

  arb_state_e       state_q, state_d;
  logic [SC_W-1:0]  starve_q, starve_d;
  logic             stall_req_q, stall_req_d;
  logic             halted_q, halted_d;

  rf_wr_t           lu_entry;
  rf_wr_t           fifo_head;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  gnt_src_e         gnt_src;
  rf_wr_t           gnt_wr;

  assign lu_entry = '{addr: LU_Reg, data: LU_Data};

  // Ready is withheld during reset so no transfer is acknowledged that the
  // reset is about to discard.
  assign LU_Ready  = !reset && !fifo_full && (state_q != ST_HALTED);
  assign fifo_push = LU_Valid && LU_Ready;

  rf_wr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_lu_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_vld (fifo_push),
    .push_dat (lu_entry),
    .pop      (fifo_pop),
    .head_dat (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // Write-port grant. While halted only debug may write; otherwise WB
  // always wins and the FIFO head takes any WB-free cycle.
  always_comb begin
    gnt_src  = GNT_NONE;
    gnt_wr   = '0;
    fifo_pop = 1'b0;
    if (!reset) begin
      if (state_q == ST_HALTED) begin
        if (DBG_Write) begin
          gnt_src = GNT_DBG;
          gnt_wr  = '{addr: DBG_Reg, data: DBG_Data};
        end
      end else if (WB_C_RegWrite) begin
        gnt_src = GNT_WB;
        gnt_wr  = '{addr: WB_RegToWrite, data: WB_Result};
      end else if (!fifo_empty) begin
        gnt_src  = GNT_LU;
        gnt_wr   = fifo_head;
        fifo_pop = 1'b1;   // r0 entries pop here too, they just never assert RF_WE
      end
    end
  end

  assign RF_WE    = writes_rf(gnt_src, gnt_wr.addr);
  assign RF_WAddr = gnt_wr.addr;
  assign RF_WData = gnt_wr.data;

  // Starvation tracking: counts cycles a waiting head loses to WB.
  // Stall_Req is registered from the next count, so it rises the cycle after
  // the LIMIT-th lost cycle and falls the cycle after the head finally pops.
  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || fifo_pop) begin
      starve_d = '0;
    end else if ((gnt_src == GNT_WB) && (starve_q != STARVE_LIMIT_C)) begin
      starve_d = starve_q + 1'b1;
    end
    stall_req_d = (starve_d == STARVE_LIMIT_C);
  end

  // Halt sequencing. DRAIN waits until nothing is queued, in flight, or
  // being offered this cycle, so no LU result can arrive after the freeze.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (WB_C_Halt) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if ((fifo_count == '0) && !LU_Busy && !LU_Valid) state_d = ST_HALTED;
      end
      ST_HALTED: begin
        state_d = ST_HALTED;   // leaves only through reset
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
    halted_d = (state_d == ST_HALTED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      starve_q    <= '0;
      stall_req_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      stall_req_q <= stall_req_d;
      halted_q    <= halted_d;
    end
  end

  assign Stall_Req = stall_req_q;
  assign Halted    = halted_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: single-cycle vector table plus multi-cycle sequences.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: every register-file write is matched against an expected-write queue.
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        WB_C_RegWrite;
  logic [4:0]  WB_RegToWrite;
  logic [31:0] WB_Result;
  logic        WB_C_Halt;
  logic        LU_Valid;
  logic [4:0]  LU_Reg;
  logic [31:0] LU_Data;
  logic        LU_Busy;
  logic        LU_Ready;
  logic        DBG_Write;
  logic [4:0]  DBG_Reg;
  logic [31:0] DBG_Data;
  logic        RF_WE;
  logic [4:0]  RF_WAddr;
  logic [31:0] RF_WData;
  logic        Stall_Req;
  logic        Halted;

  rf_write_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .WB_C_RegWrite (WB_C_RegWrite),
    .WB_RegToWrite (WB_RegToWrite),
    .WB_Result     (WB_Result),
    .WB_C_Halt     (WB_C_Halt),
    .LU_Valid      (LU_Valid),
    .LU_Reg        (LU_Reg),
    .LU_Data       (LU_Data),
    .LU_Busy       (LU_Busy),
    .LU_Ready      (LU_Ready),
    .DBG_Write     (DBG_Write),
    .DBG_Reg       (DBG_Reg),
    .DBG_Data      (DBG_Data),
    .RF_WE         (RF_WE),
    .RF_WAddr      (RF_WAddr),
    .RF_WData      (RF_WData),
    .Stall_Req     (Stall_Req),
    .Halted        (Halted)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [36:0] sb_q[$];
  logic [36:0] mon_exp;

  typedef struct {
    logic        wb_we;
    logic [4:0]  wb_reg;
    logic [31:0] wb_dat;
    logic        dbg_we;
    logic [4:0]  dbg_reg;
    logic [31:0] dbg_dat;
    logic        exp_we;
    logic [4:0]  exp_addr;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t        vecs[5];
  logic [36:0] fill[4];
  logic [36:0] drains[2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_rf(input string n, input logic we, input logic [4:0] a, input logic [31:0] d);
    chk({n, "_we"}, 64'(RF_WE), 64'(we));
    chk({n, "_addr"}, 64'(RF_WAddr), 64'(a));
    chk({n, "_data"}, 64'(RF_WData), 64'(d));
  endtask

  task automatic idle();
    WB_C_RegWrite = 1'b0; WB_RegToWrite = '0; WB_Result = '0; WB_C_Halt = 1'b0;
    LU_Valid = 1'b0; LU_Reg = '0; LU_Data = '0; LU_Busy = 1'b0;
    DBG_Write = 1'b0; DBG_Reg = '0; DBG_Data = '0;
  endtask

  // WB request that is expected to win the port (non-zero register).
  task automatic wb(input logic [4:0] r, input logic [31:0] d);
    WB_C_RegWrite = 1'b1; WB_RegToWrite = r; WB_Result = d;
    sb_q.push_back({r, d});
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Every real write must be the oldest outstanding expectation.
  always @(negedge clk) begin
    if (RF_WE === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got write r%0d=0x%0h, expected no write", RF_WAddr, RF_WData);
      end else begin
        mon_exp = sb_q.pop_front();
        chk("sb_write", {27'd0, RF_WAddr, RF_WData}, {27'd0, mon_exp});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, expected finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1'b1, 5'd5,  32'h1234,     1'b0, 5'd0, 32'h0,  1'b1, 5'd5,  32'h1234};
    vecs[1] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0,  32'h0};
    vecs[2] = '{1'b1, 5'd0,  32'hCAFE,     1'b0, 5'd0, 32'h0,  1'b0, 5'd0,  32'hCAFE};
    vecs[3] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9, 32'h55, 1'b0, 5'd0,  32'h0};
    vecs[4] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 5'd2, 32'h77, 1'b1, 5'd31, 32'hFFFFFFFF};
    fill[0]   = {5'd0,  32'hD0};
    fill[1]   = {5'd10, 32'hA10};
    fill[2]   = {5'd0,  32'hD2};
    fill[3]   = {5'd11, 32'hB11};
    drains[0] = {5'd20, 32'h2020};
    drains[1] = {5'd21, 32'h2121};

    // Reset with a WB request pending: nothing may be written.
    idle();
    reset = 1'b1;
    WB_C_RegWrite = 1'b1; WB_RegToWrite = 5'd5; WB_Result = 32'h1234;
    nxt(); nxt(); mid();
    chk_rf("reset", 1'b0, 5'd0, 32'h0);
    chk("reset_stall", 64'(Stall_Req), 64'd0);
    chk("reset_halted", 64'(Halted), 64'd0);
    nxt();
    reset = 1'b0;

    // Single-cycle grant table in RUN with the FIFO empty.
    for (int i = 0; i < 5; i++) begin
      idle();
      WB_C_RegWrite = vecs[i].wb_we;  WB_RegToWrite = vecs[i].wb_reg; WB_Result = vecs[i].wb_dat;
      DBG_Write     = vecs[i].dbg_we; DBG_Reg       = vecs[i].dbg_reg; DBG_Data = vecs[i].dbg_dat;
      if (vecs[i].exp_we) sb_q.push_back({vecs[i].exp_addr, vecs[i].exp_dat});
      mid();
      chk_rf($sformatf("vec%0d", i), vecs[i].exp_we, vecs[i].exp_addr, vecs[i].exp_dat);
      chk($sformatf("vec%0d_ready", i), 64'(LU_Ready), 64'd1);
      nxt();
    end

    // LU result is written the cycle after acceptance, and yields to WB.
    idle(); LU_Valid = 1'b1; LU_Reg = 5'd7; LU_Data = 32'hAAAA;
    mid(); chk("lu_ready", 64'(LU_Ready), 64'd1); chk_rf("lu_push_cycle", 1'b0, 5'd0, 32'h0); nxt();
    idle(); sb_q.push_back({5'd7, 32'hAAAA});
    mid(); chk_rf("lu_next", 1'b1, 5'd7, 32'hAAAA); nxt();
    idle(); LU_Valid = 1'b1; LU_Reg = 5'd7; LU_Data = 32'hBBBB;
    mid(); nxt();
    idle(); wb(5'd3, 32'h3333);
    mid(); chk_rf("wb_first", 1'b1, 5'd3, 32'h3333); nxt();
    idle(); sb_q.push_back({5'd7, 32'hBBBB});
    mid(); chk_rf("lu_after_wb", 1'b1, 5'd7, 32'hBBBB); nxt();

    // Starvation: head loses 8 cycles to WB, then Stall_Req rises.
    idle(); LU_Valid = 1'b1; LU_Reg = 5'd7; LU_Data = 32'h7777; wb(5'd1, 32'h100);
    mid(); nxt();
    for (int i = 1; i <= 9; i++) begin
      idle(); wb(5'(i + 1), 32'h100 + 32'(i));
      mid(); chk($sformatf("starve_%0d", i), 64'(Stall_Req), (i == 9) ? 64'd1 : 64'd0); nxt();
    end
    idle(); sb_q.push_back({5'd7, 32'h7777});
    mid(); chk_rf("starve_pop", 1'b1, 5'd7, 32'h7777); chk("stall_hold", 64'(Stall_Req), 64'd1); nxt();
    idle();
    mid(); chk("stall_drop", 64'(Stall_Req), 64'd0); chk_rf("starve_after", 1'b0, 5'd0, 32'h0); nxt();

    // Fill the FIFO behind WB, push while full is dropped, r0 entries pop silently.
    for (int i = 0; i < 4; i++) begin
      idle(); wb(5'(16 + i), 32'hF00 + 32'(i));
      LU_Valid = 1'b1; {LU_Reg, LU_Data} = fill[i];
      mid(); chk($sformatf("fill_ready_%0d", i), 64'(LU_Ready), 64'd1); nxt();
    end
    idle(); wb(5'd20, 32'hF04); LU_Valid = 1'b1; LU_Reg = 5'd12; LU_Data = 32'hDEAD;
    mid(); chk("full_ready", 64'(LU_Ready), 64'd0); nxt();
    for (int i = 0; i < 4; i++) begin
      idle();
      if (fill[i][36:32] != 5'd0) sb_q.push_back(fill[i]);
      mid();
      chk_rf($sformatf("pop_%0d", i), fill[i][36:32] != 5'd0, fill[i][36:32], fill[i][31:0]);
      chk($sformatf("pop_ready_%0d", i), 64'(LU_Ready), (i == 0) ? 64'd0 : 64'd1);
      nxt();
    end
    idle();
    mid(); chk_rf("full_push_dropped", 1'b0, 5'd0, 32'h0); nxt();

    // Halt with two entries queued and the LU busy for three cycles.
    idle(); wb(5'd1, 32'h11); LU_Valid = 1'b1; LU_Reg = 5'd20; LU_Data = 32'h2020;
    mid(); nxt();
    idle(); wb(5'd2, 32'h22); WB_C_Halt = 1'b1; LU_Valid = 1'b1; LU_Reg = 5'd21; LU_Data = 32'h2121;
    mid(); chk_rf("halt_wb", 1'b1, 5'd2, 32'h22); nxt();
    for (int i = 0; i < 3; i++) begin
      idle(); LU_Busy = 1'b1;
      if (i < 2) sb_q.push_back(drains[i]);
      mid();
      if (i < 2) chk_rf($sformatf("drain_%0d", i), 1'b1, drains[i][36:32], drains[i][31:0]);
      else       chk_rf("drain_busy", 1'b0, 5'd0, 32'h0);
      chk($sformatf("drain_halted_%0d", i), 64'(Halted), 64'd0);
      nxt();
    end
    idle();
    mid(); chk("halt_pending", 64'(Halted), 64'd0); chk("drain_ready", 64'(LU_Ready), 64'd1); nxt();
    idle(); WB_C_RegWrite = 1'b1; WB_RegToWrite = 5'd4; WB_Result = 32'h44;
    mid();
    chk("halted", 64'(Halted), 64'd1);
    chk("halted_ready", 64'(LU_Ready), 64'd0);
    chk_rf("halted_wb_ignored", 1'b0, 5'd0, 32'h0);
    nxt();
    idle(); WB_C_RegWrite = 1'b1; WB_RegToWrite = 5'd4; WB_Result = 32'h44;
    DBG_Write = 1'b1; DBG_Reg = 5'd9; DBG_Data = 32'h55; sb_q.push_back({5'd9, 32'h55});
    mid(); chk_rf("dbg_write", 1'b1, 5'd9, 32'h55); nxt();
    idle(); DBG_Write = 1'b1; DBG_Reg = 5'd0; DBG_Data = 32'h66;
    mid(); chk_rf("dbg_r0", 1'b0, 5'd0, 32'h66); nxt();

    // Reset leaves HALTED and returns to RUN.
    idle(); reset = 1'b1; WB_C_RegWrite = 1'b1; WB_RegToWrite = 5'd5; WB_Result = 32'h5;
    mid(); chk_rf("reset_halt_rf", 1'b0, 5'd0, 32'h0); nxt();
    mid(); chk("reset_halt_halted", 64'(Halted), 64'd0); chk("reset_halt_stall", 64'(Stall_Req), 64'd0); nxt();
    reset = 1'b0; idle(); wb(5'd5, 32'h5555);
    mid();
    chk_rf("post_reset_wb", 1'b1, 5'd5, 32'h5555);
    chk("post_reset_ready", 64'(LU_Ready), 64'd1);
    chk("post_reset_halted", 64'(Halted), 64'd0);
    nxt();

    // Reset mid-operation drops a starved FIFO entry and the pending stall.
    idle(); LU_Valid = 1'b1; LU_Reg = 5'd13; LU_Data = 32'h1313; wb(5'd1, 32'h200);
    mid(); nxt();
    for (int i = 1; i <= 9; i++) begin
      idle(); wb(5'd2, 32'h200 + 32'(i));
      mid();
      if (i == 9) chk("pre_reset_stall", 64'(Stall_Req), 64'd1);
      nxt();
    end
    idle(); reset = 1'b1;
    mid(); chk_rf("reset_mid_rf", 1'b0, 5'd0, 32'h0); nxt();
    idle(); reset = 1'b0;
    mid(); chk("reset_mid_stall", 64'(Stall_Req), 64'd0); chk_rf("reset_mid_discard", 1'b0, 5'd0, 32'h0); nxt();
    idle();
    mid(); chk_rf("reset_mid_idle", 1'b0, 5'd0, 32'h0); nxt();

    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
